adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
//  Parametrised multi-channel ADC capture controller with pre-trigger history.
//  Samples CH_NUM parallel ADC channels into internal circular buffers, arms on
//  start, fires on a level crossing of one selected channel, then freezes a
//  DEPTH-sample record per channel for sequential readout by the MCU interface.
// PARAMETERS
//  DATA_W       8     ADC sample width, unsigned
//  CH_NUM       4     channel count (1..8)
//  DEPTH        1024  samples per channel record, power of 2
//  AW           10    address width, log2(DEPTH)
//  AUTO_TIMEOUT 65535 valid samples waited in WAIT_TRIG before forced trigger
// PORTS
//  Clk        in  1             system clock
//  Reset      in  1             async reset, active-high
//  ad_data    in  CH_NUM*DATA_W channel k at [k*DATA_W +: DATA_W]
//  ad_valid   in  1             qualifies ad_data this cycle
//  start      in  1             pulse: arm capture (discards held record)
//  trig_level in  DATA_W        trigger threshold, unsigned
//  trig_ch    in  3             trigger source channel (>=CH_NUM -> channel 0)
//  trig_edge  in  1             0 rising, 1 falling
//  pre_len    in  AW            pre-trigger samples, sampled on start
//  busy       out 1             high in ARM/WAIT_TRIG/POST
//  triggered  out 1             high from trigger until next start
//  cap_done   out 1             record ready, high until readout completes
//  auto_trig  out 1             record was force-triggered
//  rd_req     in  1             pulse: read next word
//  rd_data    out DATA_W        read word, valid with rd_valid
//  rd_valid   out 1             1-cycle pulse, 1 clock after accepted rd_req
//  rd_ch      out 3             channel of current rd_data
//  rd_last    out 1             with rd_valid on final word of final channel
//  empty      out 1             no unread data held
// BEHAVIOUR
//  Reset: all outputs 0 except empty=1; FSM IDLE; pointers/counters 0.
//  FSM: IDLE -start-> ARM -pre_cnt==pre_len-> WAIT_TRIG -trig-> POST
//       -post_cnt==DEPTH-pre_len-> DONE -all words read-> IDLE.
//  start in IDLE or DONE: latch pre_len, clear flags/counters, go ARM;
//   ignored in ARM/WAIT_TRIG/POST.
//  Writes: every ad_valid cycle in ARM/WAIT_TRIG/POST writes all channels at wp;
//   wp increments mod DEPTH (wraps silently). No write when ad_valid=0.
//  ARM: counts valid samples to pre_len; pre_len=0 -> WAIT_TRIG next cycle.
//  Trigger (only in WAIT_TRIG, only on ad_valid): prev = last valid sample of
//   trig_ch. Rising: prev<=trig_level && cur>trig_level.
//   Falling: prev>trig_level && cur<=trig_level. prev invalid on first sample
//   after start (no trigger on it). Trigger sample counts as first post sample.
//  On trigger: start_addr = wp - pre_len (mod 2^AW); triggered=1.
//  POST: writes DEPTH-pre_len samples incl. trigger sample, then DONE:
//   busy=0, cap_done=1, empty=0.
//  Readout (DONE only): rd_req accepted when empty=0; rd_data from
//   channel rd_ch at start_addr+idx; channel-major order, ch0 idx0..DEPTH-1,
//   then ch1 ... After last word: rd_last=1 with rd_valid, empty=1,
//   cap_done=0 same cycle, FSM IDLE. rd_req while empty=1 ignored.
//  rd_req and start same cycle in DONE: start wins, record discarded, no rd_valid.
//  Reset mid-operation: immediate return to reset state; buffer contents undefined.
//  Trigger inputs (trig_level/ch/edge) live; not latched.
// CONFIGURATION
//  AUTO_TRIG_EN defined: in WAIT_TRIG a counter of valid samples reaching
//   AUTO_TIMEOUT forces trigger on that sample; auto_trig=1 until next start.
//   Real trigger on same sample -> auto_trig=0.
//  Not defined: WAIT_TRIG waits indefinitely; auto_trig tied 0; no counter logic.
// TESTING (DATA_W=8, CH_NUM=2, DEPTH=16, AW=4)
//  1 Reset held then released -> busy=0, cap_done=0, empty=1, rd_valid=0.
//  2 pre_len=4, level=0x80 rising, ch0 ramp 0x70..+1, ch1=~ch0, start -> trigger
//    on 0x81; readout ch0 = 0x7D..0x8C (16 words), then ch1 = ~same, rd_last on 32nd.
//  3 Falling edge, level=0x40, ch1 steps 0x50->0x40 -> trigger on 0x40 sample;
//    0x50->0x41 no trigger; ad_valid toggling 1/0 -> record still 16 contiguous valid samples.
//  4 pre_len=0 and pre_len=15 -> word0 = trigger sample / word15 = trigger sample.
//  5 start asserted mid-POST -> ignored; start with rd_req in DONE -> rearm, no rd_valid.
//  6 AUTO_TRIG_EN, AUTO_TIMEOUT=20, constant 0x10 -> forced trigger on 20th WAIT_TRIG
//    sample, auto_trig=1; without macro cap_done stays 0 after 1000 samples.

Source files
------------

// File: rtl/adc_capture_ctrl_if.sv
// ADC sample stream and MCU readout bus of adc_capture_ctrl.
// master = ADC/MCU side that drives samples and read requests, slave = capture controller.
interface adc_capture_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int CH_NUM = 4
);
   logic [CH_NUM*DATA_W-1:0] ad_data;
   logic                     ad_valid;
   logic                     rd_req;
   logic [DATA_W-1:0]        rd_data;
   logic                     rd_valid;
   logic [2:0]               rd_ch;
   logic                     rd_last;
   logic                     empty;

   modport master (
      output ad_data, ad_valid, rd_req,
      input  rd_data, rd_valid, rd_ch, rd_last, empty
   );

   modport slave (
      input  ad_data, ad_valid, rd_req,
      output rd_data, rd_valid, rd_ch, rd_last, empty
   );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Multi-channel ADC capture controller: circular pre-trigger history, level trigger, channel-major readout.
// Optional forced trigger after AUTO_TIMEOUT idle samples when AUTO_TRIG_EN is defined.
module adc_capture_ctrl #(
   parameter int DATA_W       = 8,
   parameter int CH_NUM       = 4,
   parameter int DEPTH        = 1024,
   parameter int AW           = 10,
   parameter int AUTO_TIMEOUT = 65535
) (
   input  logic              Clk,
   input  logic              Reset,
   adc_capture_ctrl_if.slave bus,
   input  logic              start,
   input  logic [DATA_W-1:0] trig_level,
   input  logic [2:0]        trig_ch,
   input  logic              trig_edge,
   input  logic [AW-1:0]     pre_len,
   output logic              busy,
   output logic              triggered,
   output logic              cap_done,
   output logic              auto_trig
);
   localparam int              CW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic [AW:0]     DEPTH_C = DEPTH[AW:0];
   localparam logic [AW:0]     ONE_C   = {{AW{1'b0}}, 1'b1};
   localparam logic [CW-1:0]   LAST_CH = CW'(CH_NUM - 1);

   if (AUTO_TIMEOUT < 1 || CH_NUM < 1 || CH_NUM > 8 || DEPTH != 2**AW) begin : g_param_check
      $error("adc_capture_ctrl: inconsistent parameters");
   end

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_TRIG, S_POST, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     wp_q, wp_d;
   logic [AW-1:0]     pre_len_q, pre_len_d;
   logic [AW-1:0]     pre_cnt_q, pre_cnt_d;
   logic [AW:0]       post_cnt_q, post_cnt_d;
   logic [AW-1:0]     start_addr_q, start_addr_d;
   logic [AW-1:0]     rd_idx_q, rd_idx_d;
   logic [CW-1:0]     rd_chn_q, rd_chn_d;
   logic [CW-1:0]     rd_ch_q, rd_ch_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [DATA_W-1:0] last_q [CH_NUM];
   logic [DATA_W-1:0] last_d [CH_NUM];
   logic              prev_vld_q, prev_vld_d;
   logic              busy_q, busy_d;
   logic              triggered_q, triggered_d;
   logic              cap_done_q, cap_done_d;
   logic              empty_q, empty_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_last_q, rd_last_d;

   logic [DATA_W-1:0] mem [CH_NUM][DEPTH];
   logic [DATA_W-1:0] cur [CH_NUM];
   logic [DATA_W-1:0] prev_s, cur_s;
   logic [CW-1:0]     trig_sel;
   logic [AW-1:0]     rd_addr;
   logic [AW:0]       post_len;
   logic              wr_en, hit, fire, arm_now;

`ifdef AUTO_TRIG_EN
   localparam int          TW        = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_C = TW'(AUTO_TIMEOUT);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          auto_trig_q, auto_trig_d;

   assign fire      = hit || (to_cnt_q + 1'b1 == TIMEOUT_C);
   assign auto_trig = auto_trig_q;
`else
   assign fire      = hit;
   assign auto_trig = 1'b0;
`endif

   always_comb begin
      for (int k = 0; k < CH_NUM; k++) cur[k] = bus.ad_data[k*DATA_W +: DATA_W];
   end

   // Out-of-range source channel falls back to channel 0; trigger inputs stay live.
   assign trig_sel = (int'(trig_ch) < CH_NUM) ? CW'(trig_ch) : '0;
   assign prev_s   = last_q[trig_sel];
   assign cur_s    = cur[trig_sel];
   assign hit      = prev_vld_q && (trig_edge ? (prev_s > trig_level && cur_s <= trig_level)
                                              : (prev_s <= trig_level && cur_s > trig_level));
   assign post_len = DEPTH_C - {1'b0, pre_len_q};
   assign arm_now  = start && (state_q == S_IDLE || state_q == S_DONE);
   assign rd_addr  = start_addr_q + rd_idx_q;

   // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d      = state_q;
      wp_d         = wp_q;
      pre_len_d    = pre_len_q;
      pre_cnt_d    = pre_cnt_q;
      post_cnt_d   = post_cnt_q;
      start_addr_d = start_addr_q;
      rd_idx_d     = rd_idx_q;
      rd_chn_d     = rd_chn_q;
      rd_ch_d      = rd_ch_q;
      rd_data_d    = rd_data_q;
      last_d       = last_q;
      prev_vld_d   = prev_vld_q;
      triggered_d  = triggered_q;
      cap_done_d   = cap_done_q;
      empty_d      = empty_q;
      rd_valid_d   = 1'b0;
      rd_last_d    = 1'b0;
      wr_en        = 1'b0;
`ifdef AUTO_TRIG_EN
      to_cnt_d     = to_cnt_q;
      auto_trig_d  = auto_trig_q;
`endif

      if (arm_now) begin
         state_d     = S_ARM;
         pre_len_d   = pre_len;
         pre_cnt_d   = '0;
         post_cnt_d  = '0;
         wp_d        = '0;
         rd_idx_d    = '0;
         rd_chn_d    = '0;
         prev_vld_d  = 1'b0;
         triggered_d = 1'b0;
         cap_done_d  = 1'b0;
         empty_d     = 1'b1;
`ifdef AUTO_TRIG_EN
         to_cnt_d    = '0;
         auto_trig_d = 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_ARM: begin
               if (bus.ad_valid) begin
                  wr_en     = 1'b1;
                  pre_cnt_d = pre_cnt_q + 1'b1;
               end
               if (pre_cnt_q == pre_len_q || (bus.ad_valid && pre_cnt_d == pre_len_q))
                  state_d = S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
               if (bus.ad_valid) begin
                  wr_en = 1'b1;
`ifdef AUTO_TRIG_EN
                  to_cnt_d = to_cnt_q + 1'b1;
`endif
                  if (fire) begin
                     // The trigger sample sits at wp, so the record starts pre_len words back.
                     start_addr_d = wp_q - pre_len_q;
                     triggered_d  = 1'b1;
                     post_cnt_d   = ONE_C;
`ifdef AUTO_TRIG_EN
                     auto_trig_d  = !hit;
`endif
                     if (post_len == ONE_C) begin
                        state_d    = S_DONE;
                        cap_done_d = 1'b1;
                        empty_d    = 1'b0;
                     end else begin
                        state_d = S_POST;
                     end
                  end
               end
            end
            S_POST: begin
               if (bus.ad_valid) begin
                  wr_en      = 1'b1;
                  post_cnt_d = post_cnt_q + 1'b1;
                  if (post_cnt_d == post_len) begin
                     state_d    = S_DONE;
                     cap_done_d = 1'b1;
                     empty_d    = 1'b0;
                  end
               end
            end
            S_DONE: begin
               if (bus.rd_req && !empty_q) begin
                  rd_data_d  = mem[rd_chn_q][rd_addr];
                  rd_ch_d    = rd_chn_q;
                  rd_valid_d = 1'b1;
                  if (rd_chn_q == LAST_CH && &rd_idx_q) begin
                     rd_last_d  = 1'b1;
                     empty_d    = 1'b1;
                     cap_done_d = 1'b0;
                     state_d    = S_IDLE;
                  end else begin
                     rd_idx_d = rd_idx_q + 1'b1;
                     if (&rd_idx_q) rd_chn_d = rd_chn_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      if (wr_en) begin
         wp_d       = wp_q + 1'b1;
         last_d     = cur;
         prev_vld_d = 1'b1;
      end

      busy_d = (state_d == S_ARM) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         wp_q         <= '0;
         pre_len_q    <= '0;
         pre_cnt_q    <= '0;
         post_cnt_q   <= '0;
         start_addr_q <= '0;
         rd_idx_q     <= '0;
         rd_chn_q     <= '0;
         rd_ch_q      <= '0;
         rd_data_q    <= '0;
         for (int k = 0; k < CH_NUM; k++) last_q[k] <= '0;
         prev_vld_q   <= 1'b0;
         busy_q       <= 1'b0;
         triggered_q  <= 1'b0;
         cap_done_q   <= 1'b0;
         empty_q      <= 1'b1;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
`ifdef AUTO_TRIG_EN
         to_cnt_q     <= '0;
         auto_trig_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wp_q         <= wp_d;
         pre_len_q    <= pre_len_d;
         pre_cnt_q    <= pre_cnt_d;
         post_cnt_q   <= post_cnt_d;
         start_addr_q <= start_addr_d;
         rd_idx_q     <= rd_idx_d;
         rd_chn_q     <= rd_chn_d;
         rd_ch_q      <= rd_ch_d;
         rd_data_q    <= rd_data_d;
         last_q       <= last_d;
         prev_vld_q   <= prev_vld_d;
         busy_q       <= busy_d;
         triggered_q  <= triggered_d;
         cap_done_q   <= cap_done_d;
         empty_q      <= empty_d;
         rd_valid_q   <= rd_valid_d;
         rd_last_q    <= rd_last_d;
`ifdef AUTO_TRIG_EN
         to_cnt_q     <= to_cnt_d;
         auto_trig_q  <= auto_trig_d;
`endif
      end
   end

   // NOTE: the sample store is deliberately not reset; it is only read after a full record is written.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         for (int k = 0; k < CH_NUM; k++) mem[k][wp_q] <= cur[k];
      end
   end

   assign busy         = busy_q;
   assign triggered    = triggered_q;
   assign cap_done     = cap_done_q;
   assign bus.empty    = empty_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_ch    = 3'(rd_ch_q);
   assign bus.rd_last  = rd_last_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl (DATA_W=8, CH_NUM=2, DEPTH=16, AW=4, AUTO_TIMEOUT=20).
// Table of ramp captures plus hand sequences for falling steps, start collisions, timeout and reset.
module tb_adc_capture_ctrl;
   localparam int DATA_W = 8, CH_NUM = 2, DEPTH = 16, AW = 4, AUTO_TIMEOUT = 20;
   localparam int NV = 6;

   typedef struct {
      logic [3:0] pre;
      logic       edg;
      logic [2:0] ch;
      logic [7:0] level;
      logic [7:0] base;
      logic       gap;
      logic [7:0] tval;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       start;
   logic [7:0] trig_level;
   logic [2:0] trig_ch;
   logic       trig_edge;
   logic [3:0] pre_len;
   logic       busy, triggered, cap_done, auto_trig;
   int         checks = 0;
   int         errors = 0;

   always #5 Clk = ~Clk;

   adc_capture_ctrl_if #(.DATA_W(DATA_W), .CH_NUM(CH_NUM)) bus ();

   adc_capture_ctrl #(
      .DATA_W(DATA_W), .CH_NUM(CH_NUM), .DEPTH(DEPTH), .AW(AW), .AUTO_TIMEOUT(AUTO_TIMEOUT)
   ) dut (
      .Clk(Clk), .Reset(Reset), .bus(bus), .start(start), .trig_level(trig_level),
      .trig_ch(trig_ch), .trig_edge(trig_edge), .pre_len(pre_len), .busy(busy),
      .triggered(triggered), .cap_done(cap_done), .auto_trig(auto_trig)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic feed(input logic [7:0] c0, input logic [7:0] c1, input logic v);
      bus.ad_data  = {c1, c0};
      bus.ad_valid = v;
      @(posedge Clk); #1;
      bus.ad_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
   endtask

   task automatic read_word(output logic [7:0] d, output logic [2:0] c, output logic v, output logic l);
      bus.rd_req = 1'b1;
      @(posedge Clk); #1;
      bus.rd_req = 1'b0;
      d = bus.rd_data;
      c = bus.rd_ch;
      v = bus.rd_valid;
      l = bus.rd_last;
   endtask

   // Ramp on ch0 with ch1 = ~ch0; stops at trigger or at record completion, bounded.
   task automatic ramp_until(inout logic [7:0] val, input logic gap, input logic stop_trig);
      for (int cnt = 0; cnt < 200; cnt++) begin
         if (stop_trig ? triggered : cap_done) break;
         if (gap && cnt[0]) feed(8'hEE, 8'hEE, 1'b0);
         else begin
            feed(val, ~val, 1'b1);
            val++;
         end
      end
   endtask

   task automatic check_record(input logic [7:0] exp [32], input string tag);
      logic [7:0] d;
      logic [2:0] c;
      logic       v, l;
      for (int i = 0; i < 32; i++) begin
         read_word(d, c, v, l);
         check($sformatf("%s w%0d rd_valid", tag, i), 32'(v), 32'd1);
         check($sformatf("%s w%0d rd_data", tag, i), 32'(d), 32'(exp[i]));
         check($sformatf("%s w%0d rd_ch", tag, i), 32'(c), (i < 16) ? 32'd0 : 32'd1);
         check($sformatf("%s w%0d rd_last", tag, i), 32'(l), (i == 31) ? 32'd1 : 32'd0);
      end
      check({tag, " empty after drain"}, 32'(bus.empty), 32'd1);
      check({tag, " cap_done after drain"}, 32'(cap_done), 32'd0);
      read_word(d, c, v, l);
      check({tag, " rd_req while empty"}, 32'(v), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [NV];
      vec_t       r;
      logic [7:0] expw [32];
      logic [7:0] val, w, d;
      logic [2:0] c;
      logic       v, l;
      string      tag;

      vecs[0] = '{pre: 4'd4,  edg: 1'b0, ch: 3'd0, level: 8'h80, base: 8'h70, gap: 1'b0, tval: 8'h81};
      vecs[1] = '{pre: 4'd0,  edg: 1'b0, ch: 3'd0, level: 8'h80, base: 8'h70, gap: 1'b0, tval: 8'h81};
      vecs[2] = '{pre: 4'd15, edg: 1'b0, ch: 3'd0, level: 8'h80, base: 8'h70, gap: 1'b0, tval: 8'h81};
      vecs[3] = '{pre: 4'd8,  edg: 1'b1, ch: 3'd1, level: 8'h40, base: 8'hA0, gap: 1'b0, tval: 8'hBF};
      vecs[4] = '{pre: 4'd2,  edg: 1'b0, ch: 3'd5, level: 8'h90, base: 8'h80, gap: 1'b0, tval: 8'h91};
      vecs[5] = '{pre: 4'd6,  edg: 1'b0, ch: 3'd0, level: 8'h80, base: 8'h70, gap: 1'b1, tval: 8'h81};

      Reset = 1'b1; start = 1'b0; trig_level = '0; trig_ch = '0; trig_edge = 1'b0; pre_len = '0;
      bus.ad_data = '0; bus.ad_valid = 1'b0; bus.rd_req = 1'b0;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(posedge Clk); #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset cap_done", 32'(cap_done), 32'd0);
      check("reset empty", 32'(bus.empty), 32'd1);
      check("reset rd_valid", 32'(bus.rd_valid), 32'd0);
      check("reset triggered", 32'(triggered), 32'd0);
      check("reset auto_trig", 32'(auto_trig), 32'd0);
      read_word(d, c, v, l);
      check("idle rd_req ignored", 32'(v), 32'd0);

      for (int vi = 0; vi < NV; vi++) begin
         r   = vecs[vi];
         tag = $sformatf("vec%0d", vi);
         trig_level = r.level; trig_ch = r.ch; trig_edge = r.edg; pre_len = r.pre;
         pulse_start();
         check({tag, " busy after start"}, 32'(busy), 32'd1);
         check({tag, " triggered after start"}, 32'(triggered), 32'd0);
         val = r.base;
         ramp_until(val, r.gap, 1'b0);
         check({tag, " cap_done"}, 32'(cap_done), 32'd1);
         check({tag, " busy done"}, 32'(busy), 32'd0);
         check({tag, " triggered"}, 32'(triggered), 32'd1);
         check({tag, " empty done"}, 32'(bus.empty), 32'd0);
         check({tag, " auto_trig"}, 32'(auto_trig), 32'd0);
         for (int i = 0; i < 32; i++) begin
            w = r.tval - 8'(r.pre) + 8'(i % 16);
            expw[i] = (i < 16) ? w : ~w;
         end
         check_record(expw, tag);
      end

      // Falling on ch1: 0x50->0x41 must not fire, 0x50->0x40 must; ch0 tags the sample index.
      trig_level = 8'h40; trig_ch = 3'd1; trig_edge = 1'b1; pre_len = 4'd0;
      pulse_start();
      feed(8'd0, 8'h50, 1'b1);
      feed(8'd1, 8'h41, 1'b1);
      feed(8'd2, 8'h50, 1'b1);
      feed(8'd3, 8'h41, 1'b1);
      feed(8'd4, 8'h50, 1'b1);
      check("fall 0x41 no trigger", 32'(triggered), 32'd0);
      feed(8'd5, 8'h40, 1'b1);
      check("fall 0x40 trigger", 32'(triggered), 32'd1);
      for (int n = 6; n < 21; n++) feed(8'(n), 8'h30, 1'b1);
      check("fall cap_done", 32'(cap_done), 32'd1);
      for (int i = 0; i < 32; i++)
         expw[i] = (i < 16) ? 8'(5 + i) : ((i == 16) ? 8'h40 : 8'h30);
      check_record(expw, "fall");

      // start during POST is ignored; start together with rd_req in DONE rearms without a read.
      trig_level = 8'h80; trig_ch = 3'd0; trig_edge = 1'b0; pre_len = 4'd4;
      pulse_start();
      val = 8'h70;
      ramp_until(val, 1'b0, 1'b1);
      check("midpost triggered", 32'(triggered), 32'd1);
      start = 1'b1;
      feed(val, ~val, 1'b1);
      val++;
      start = 1'b0;
      check("midpost start ignored triggered", 32'(triggered), 32'd1);
      check("midpost start ignored busy", 32'(busy), 32'd1);
      ramp_until(val, 1'b0, 1'b0);
      check("midpost cap_done", 32'(cap_done), 32'd1);
      read_word(d, c, v, l);
      check("midpost word0", 32'(d), 32'h7D);
      start = 1'b1; bus.rd_req = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0; bus.rd_req = 1'b0;
      check("start+rd_req rd_valid", 32'(bus.rd_valid), 32'd0);
      check("start+rd_req busy", 32'(busy), 32'd1);
      check("start+rd_req cap_done", 32'(cap_done), 32'd0);
      check("start+rd_req empty", 32'(bus.empty), 32'd1);
      check("start+rd_req triggered", 32'(triggered), 32'd0);
      Reset = 1'b1;
      #1;
      check("async reset busy", 32'(busy), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      // Constant input never crosses the level; only the timeout can end WAIT_TRIG.
      trig_level = 8'h80; pre_len = 4'd0;
      pulse_start();
`ifdef AUTO_TRIG_EN
      for (int n = 0; n < 20; n++) feed(8'h10, 8'h10, 1'b1);
      check("auto 19 samples triggered", 32'(triggered), 32'd0);
      check("auto 19 samples auto_trig", 32'(auto_trig), 32'd0);
      feed(8'h10, 8'h10, 1'b1);
      check("auto 20th triggered", 32'(triggered), 32'd1);
      check("auto 20th auto_trig", 32'(auto_trig), 32'd1);
      for (int n = 0; n < 15; n++) feed(8'h10, 8'h10, 1'b1);
      check("auto cap_done", 32'(cap_done), 32'd1);
      check("auto auto_trig held", 32'(auto_trig), 32'd1);
      pulse_start();
      check("auto cleared by start", 32'(auto_trig), 32'd0);
`else
      for (int n = 0; n < 1000; n++) feed(8'h10, 8'h10, 1'b1);
      check("no auto cap_done", 32'(cap_done), 32'd0);
      check("no auto triggered", 32'(triggered), 32'd0);
      check("no auto busy", 32'(busy), 32'd1);
      check("no auto auto_trig", 32'(auto_trig), 32'd0);
`endif

      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(posedge Clk); #1;
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset empty", 32'(bus.empty), 32'd1);
      check("mid reset cap_done", 32'(cap_done), 32'd0);
      check("mid reset triggered", 32'(triggered), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
